// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types, defaults and elaboration helpers for bin2bcd_seq
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_BIN_W  = 32;
  localparam int DEF_DIGITS = 10;

  // Width of the packed BCD bus for a given digit count.
  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  // ceil(bin_w * log10(2)) in integer arithmetic; the constant rounds
  // log10(2) slightly up so the result never under-reports.
  function automatic int digits_needed(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// rtl/bin2bcd_seq_add3.sv - single BCD digit add-3 corrector
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits of 5 or more would carry past 9 after the next doubling.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  signed_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  ovf
);

  localparam int BCD_W  = bcd_width(DIGITS);
  localparam int CNT_W  = $clog2(BIN_W + 1);
  // With enough digits the top digit can never reach 5, so ovf is tied off.
  localparam bit NARROW = DIGITS < digits_needed(BIN_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic               neg_int_q, neg_int_d;
  logic               ovf_int_q, ovf_int_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  blank_q, blank_d;

  logic [BCD_W-1:0]   corr;
  logic [BCD_W-1:0]   acc_shift;
  logic               ovf_shift;
  logic [DIGITS-1:0]  blank_next;
  logic [BIN_W-1:0]   mag;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc_q[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  // Magnitude of the operand; the most negative value maps to 2^(BIN_W-1).
  always_comb begin
    mag = (signed_in && bin_in[BIN_W-1]) ? -bin_in : bin_in;
  end

  // One double-dabble step: corrected digits shift left, next binary bit enters.
  always_comb begin
    acc_shift  = {corr[BCD_W-2:0], sh_q[BIN_W-1]};
    ovf_shift  = ovf_int_q | (NARROW & corr[BCD_W-1]);
    last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  end

  // Leading-zero mask of the final BCD value; digit 0 is never blanked.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (acc_shift[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  // Next-state and datapath control for IDLE -> SHIFT x BIN_W -> DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    neg_int_d = neg_int_q;
    ovf_int_d = ovf_int_q;
    bcd_out_d = bcd_out_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d      = mag;
          acc_d     = '0;
          neg_int_d = signed_in && bin_in[BIN_W-1];
          ovf_int_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        acc_d     = acc_shift;
        sh_d      = {sh_q[BIN_W-2:0], 1'b0};
        ovf_int_d = ovf_shift;
        cnt_d     = cnt_q - CNT_W'(1);
        if (last_shift) begin
          state_d   = DONE;
          bcd_out_d = acc_shift;
          neg_d     = neg_int_q;
          ovf_d     = ovf_shift;
          blank_d   = blank_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      neg_int_q <= 1'b0;
      ovf_int_q <= 1'b0;
      bcd_out_q <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      neg_int_q <= neg_int_d;
      ovf_int_q <= ovf_int_d;
      bcd_out_q <= bcd_out_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign valid      = (state_q == DONE);
  assign bcd_out    = bcd_out_q;
  assign neg        = neg_q;
  assign ovf        = ovf_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed vector bench for bin2bcd_seq (10 and 8 digit instances)
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin_in;
  logic        signed_in;

  logic        ready, valid, neg, ovf;
  logic [39:0] bcd_out;
  logic [9:0]  blank_mask;

  logic        ready8, valid8, neg8, ovf8;
  logic [31:0] bcd8;
  logic [7:0]  blank8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .signed_in(signed_in),
    .ready(ready), .valid(valid), .bcd_out(bcd_out), .neg(neg),
    .blank_mask(blank_mask), .ovf(ovf)
  );

  bin2bcd_seq #(.BIN_W(32), .DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .signed_in(signed_in),
    .ready(ready8), .valid(valid8), .bcd_out(bcd8), .neg(neg8),
    .blank_mask(blank8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [31:0] bin;
    logic        sgn;
    logic [39:0] bcd;
    logic        neg;
    logic [9:0]  blank;
    logic [31:0] bcd8;
    logic        ovf8;
    logic [7:0]  blank8;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one accepted edge, then scramble the operand and wait for valid.
  task automatic convert(input logic [31:0] b, input logic s, output int lat);
    bin_in    = b;
    signed_in = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    bin_in    = ~b;
    signed_in = ~s;
    lat = 0;
    while (valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nvalid;
    int gap;
    logic [39:0] got;

    vecs[0]  = '{32'd0,          1'b0, 40'h0000000000, 1'b0, 10'b1111111110, 32'h00000000, 1'b0, 8'b11111110};
    vecs[1]  = '{32'hFFFFFFFF,   1'b0, 40'h4294967295, 1'b0, 10'b0000000000, 32'h94967295, 1'b1, 8'b00000000};
    vecs[2]  = '{32'hFFFFFFFF,   1'b1, 40'h0000000001, 1'b1, 10'b1111111110, 32'h00000001, 1'b0, 8'b11111110};
    vecs[3]  = '{32'h80000000,   1'b1, 40'h2147483648, 1'b1, 10'b0000000000, 32'h47483648, 1'b1, 8'b00000000};
    vecs[4]  = '{32'd1234,       1'b0, 40'h0000001234, 1'b0, 10'b1111110000, 32'h00001234, 1'b0, 8'b11110000};
    vecs[5]  = '{32'd123456789,  1'b0, 40'h0123456789, 1'b0, 10'b1000000000, 32'h23456789, 1'b1, 8'b00000000};
    vecs[6]  = '{32'd99999999,   1'b0, 40'h0099999999, 1'b0, 10'b1100000000, 32'h99999999, 1'b0, 8'b00000000};
    vecs[7]  = '{32'h7FFFFFFF,   1'b1, 40'h2147483647, 1'b0, 10'b0000000000, 32'h47483647, 1'b1, 8'b00000000};
    vecs[8]  = '{32'h80000000,   1'b0, 40'h2147483648, 1'b0, 10'b0000000000, 32'h47483648, 1'b1, 8'b00000000};
    vecs[9]  = '{32'hFFFFFB2E,   1'b1, 40'h0000001234, 1'b1, 10'b1111110000, 32'h00001234, 1'b0, 8'b11110000};
    vecs[10] = '{32'd100000000,  1'b0, 40'h0100000000, 1'b0, 10'b1000000000, 32'h00000000, 1'b1, 8'b11111110};

    rst = 1'b1; start = 1'b0; bin_in = '0; signed_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_bcd",   64'(bcd_out), 64'd0);
    chk("reset_neg",   64'(neg), 64'd0);
    chk("reset_blank", 64'(blank_mask), 64'd0);
    chk("reset_ovf",   64'(ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
      convert(vecs[v].bin, vecs[v].sgn, lat);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'd32);
      chk($sformatf("v%0d_ready_in_done", v), 64'(ready), 64'd0);
      chk($sformatf("v%0d_bcd", v),    64'(bcd_out),    64'(vecs[v].bcd));
      chk($sformatf("v%0d_neg", v),    64'(neg),        64'(vecs[v].neg));
      chk($sformatf("v%0d_blank", v),  64'(blank_mask), 64'(vecs[v].blank));
      chk($sformatf("v%0d_ovf", v),    64'(ovf),        64'd0);
      chk($sformatf("v%0d_valid8", v), 64'(valid8),     64'd1);
      chk($sformatf("v%0d_bcd8", v),   64'(bcd8),       64'(vecs[v].bcd8));
      chk($sformatf("v%0d_neg8", v),   64'(neg8),       64'(vecs[v].neg));
      chk($sformatf("v%0d_ovf8", v),   64'(ovf8),       64'(vecs[v].ovf8));
      chk($sformatf("v%0d_blank8", v), 64'(blank8),     64'(vecs[v].blank8));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_pulse", v), 64'(valid), 64'd0);
      chk($sformatf("v%0d_ready_after", v), 64'(ready), 64'd1);
      chk($sformatf("v%0d_bcd_hold", v),    64'(bcd_out), 64'(vecs[v].bcd));
    end

    // A second start while busy must neither queue nor disturb the first result.
    bin_in = 32'd42; signed_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nvalid = 0;
    got = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        start  = 1'b1;
        bin_in = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (valid) begin
        nvalid++;
        got = bcd_out;
      end
    end
    chk("busy_start_pulses", 64'(nvalid), 64'd1);
    chk("busy_start_result", 64'(got), 64'h42);

    // Start held high: ignored in DONE, accepted in the following IDLE cycle.
    bin_in = 32'd11; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_first_latency", 64'(lat), 64'd32);
    chk("b2b_first_bcd", 64'(bcd_out), 64'h11);
    bin_in = 32'd22;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (!ready) start = 1'b0;
    end while (valid !== 1'b1 && gap < 100);
    chk("b2b_gap", 64'(gap), 64'd34);
    chk("b2b_second_bcd", 64'(bcd_out), 64'h22);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a conversion.
    bin_in = 32'd5000; signed_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_bcd",   64'(bcd_out), 64'd0);
    chk("midrst_blank", 64'(blank_mask), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    chk("midrst_no_valid", 64'(nvalid), 64'd0);
    convert(32'd100, 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd32);
    chk("post_rst_bcd",     64'(bcd_out), 64'h100);
    chk("post_rst_blank",   64'(blank_mask), 64'(10'b1111111000));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
